// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port, variable-latency memory between instruction fetch
// and the load/store stage; data side has priority, fetch is forced through after starvation.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stallF,
    output logic              stallM,
    output logic [2:0]        fsm_state,
    output logic [3:0]        starve_count
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] BUSY_I = 3'd1;
    localparam logic [2:0] BUSY_D = 3'd2;
    localparam logic [2:0] RESP_I = 3'd3;
    localparam logic [2:0] RESP_D = 3'd4;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [2:0]        state;
    logic [3:0]        starve_cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_we;
    logic              busy;
    logic              force_fetch;

    // Handshake: a requester raises req with its payload and holds both until its
    // valid pulse; in the cycle after valid it must drop req or present a new request.
    // The memory side sees mem_req held with stable payload until mem_ack.
    assign busy        = (state == BUSY_I) || (state == BUSY_D);
    assign force_fetch = if_req && (starve_cnt == LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            starve_cnt <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_we     <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_req && !force_fetch) begin
                        state     <= BUSY_D;
                        lat_addr  <= d_addr;
                        lat_wdata <= d_wdata;
                        lat_we    <= d_we;
                        if (if_req && (starve_cnt < LIMIT)) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                    end else if (if_req) begin
                        state      <= BUSY_I;
                        lat_addr   <= if_addr;
                        lat_wdata  <= '0;
                        lat_we     <= 1'b0;
                        starve_cnt <= '0;
                    end
                end
                BUSY_I: begin
                    if (mem_ack) begin
                        state    <= RESP_I;
                        if_rdata <= mem_rdata;
                    end
                end
                BUSY_D: begin
                    if (mem_ack) begin
                        state <= RESP_D;
                        // Stores leave the last load result in place.
                        if (!lat_we) begin
                            d_rdata <= mem_rdata;
                        end
                    end
                end
                RESP_I, RESP_D: state <= IDLE;
                default:        state <= IDLE;
            endcase
        end
    end

    assign mem_req   = busy;
    assign mem_we    = busy && lat_we;
    assign mem_addr  = lat_addr;
    assign mem_wdata = busy ? lat_wdata : '0;

    assign if_valid = (state == RESP_I);
    assign d_valid  = (state == RESP_D);

    assign stallF = if_req && !if_valid;
    assign stallM = d_req && !d_valid;

    assign fsm_state    = state;
    assign starve_count = starve_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a small wait-state memory model answers the
// arbiter, and each step is checked against hand-computed values.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stallF;
    logic        stallM;
    logic [2:0]  fsm_state;
    logic [3:0]  starve_count;

    logic [31:0] tb_mem [256];
    logic [3:0]  mem_wait;
    logic [3:0]  wait_cnt;
    logic        force_ack;

    int pass_cnt;
    int total_cnt;

    logic [31:0] g_addr [6];
    logic [31:0] g_cnt  [6];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stallF(stallF), .stallM(stallM),
        .fsm_state(fsm_state), .starve_count(starve_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: acks after mem_wait cycles of mem_req, read data in the ack cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_cnt <= '0;
        else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 4'd1;
        else wait_cnt <= '0;
    end

    assign mem_ack   = force_ack || (mem_req && (wait_cnt == mem_wait));
    assign mem_rdata = tb_mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_req && mem_ack && mem_we) tb_mem[mem_addr[9:2]] = mem_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        for (int i = 0; i < 256; i++) tb_mem[i] = 32'h0;
        tb_mem[64]  = 32'h0050_0093;
        tb_mem[128] = 32'h1234_5678;
        tb_mem[32]  = 32'hA5A5_A5A5;
        tb_mem[4]   = 32'h1111_1111;
        tb_mem[8]   = 32'h2222_2222;
        g_addr = '{32'h80, 32'h80, 32'h80, 32'h80, 32'h200, 32'h80};
        g_cnt  = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd1};

        rst_n = 1'b0; force_ack = 1'b0; mem_wait = 4'd0;
        if_req = 1'b1; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

        // Reset state
        tick();
        chk("rst_state", 32'(fsm_state), 32'd0);
        chk("rst_starve", 32'(starve_count), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_valids", {30'd0, if_valid, d_valid}, 32'd0);
        chk("rst_rdata", if_rdata | d_rdata, 32'h0);
        chk("rst_stallF_follows", 32'(stallF), 32'd1);
        if_req = 1'b0;
        #1;
        chk("rst_stallF_low", 32'(stallF), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single fetch, two wait states
        if_req = 1'b1; if_addr = 32'h100; mem_wait = 4'd2;
        #1;
        chk("f_stallF_c0", 32'(stallF), 32'd1);
        chk("f_mem_req_c0", 32'(mem_req), 32'd0);
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk("f_mem_req", 32'(mem_req), 32'd1);
            chk("f_mem_addr", mem_addr, 32'h100);
            chk("f_stallF", 32'(stallF), 32'd1);
            chk("f_if_valid_low", 32'(if_valid), 32'd0);
        end
        tick();
        chk("f_if_valid_c4", 32'(if_valid), 32'd1);
        chk("f_if_rdata", if_rdata, 32'h0050_0093);
        chk("f_stallF_c4", 32'(stallF), 32'd0);
        chk("f_mem_req_c4", 32'(mem_req), 32'd0);
        if_req = 1'b0;
        tick();
        chk("f_if_valid_c5", 32'(if_valid), 32'd0);

        // Store then load, zero wait
        mem_wait = 4'd0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
        #1;
        chk("sl_stallM_c0", 32'(stallM), 32'd1);
        tick();
        chk("sl_st_mem_we", 32'(mem_we), 32'd1);
        chk("sl_st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("sl_st_mem_addr", mem_addr, 32'h40);
        tick();
        chk("sl_st_d_valid", 32'(d_valid), 32'd1);
        chk("sl_st_d_rdata", d_rdata, 32'h0);
        chk("sl_st_mem_we_off", 32'(mem_we), 32'd0);
        chk("sl_st_mem_wdata_off", mem_wdata, 32'h0);
        tick();
        d_we = 1'b0; d_wdata = 32'h5555_5555;
        chk("sl_idle_d_valid", 32'(d_valid), 32'd0);
        tick();
        chk("sl_ld_mem_req", 32'(mem_req), 32'd1);
        chk("sl_ld_mem_we", 32'(mem_we), 32'd0);
        chk("sl_ld_d_valid", 32'(d_valid), 32'd0);
        tick();
        chk("sl_ld_d_valid2", 32'(d_valid), 32'd1);
        chk("sl_ld_d_rdata", d_rdata, 32'hDEAD_BEEF);
        d_req = 1'b0;
        tick();

        // Contention: grant order D D D D I D
        if_req = 1'b1; if_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        for (int g = 0; g < 6; g++) begin
            tick();
            chk("ct_grant_addr", mem_addr, g_addr[g]);
            chk("ct_starve", 32'(starve_count), g_cnt[g]);
            tick();
            if (g == 4) begin
                chk("ct_if_valid", 32'(if_valid), 32'd1);
                chk("ct_if_rdata", if_rdata, 32'h1234_5678);
            end else begin
                chk("ct_d_valid", 32'(d_valid), 32'd1);
                chk("ct_d_rdata", d_rdata, 32'hA5A5_A5A5);
            end
            tick();
        end
        d_req = 1'b0;
        tick();
        chk("ct_tail_addr", mem_addr, 32'h200);
        chk("ct_tail_starve", 32'(starve_count), 32'd0);
        tick();
        chk("ct_tail_if_valid", 32'(if_valid), 32'd1);
        tick();
        if_req = 1'b0;
        tick();

        // Requester input change mid-access
        mem_wait = 4'd3;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        tick();
        chk("mc_mem_addr_c1", mem_addr, 32'h10);
        d_addr = 32'h20; d_we = 1'b1; d_wdata = 32'h7777_7777;
        for (int c = 2; c <= 4; c++) begin
            tick();
            chk("mc_mem_addr", mem_addr, 32'h10);
            chk("mc_mem_we", 32'(mem_we), 32'd0);
            chk("mc_d_valid_low", 32'(d_valid), 32'd0);
        end
        tick();
        chk("mc_d_valid", 32'(d_valid), 32'd1);
        chk("mc_d_rdata", d_rdata, 32'h1111_1111);
        d_req = 1'b0; d_we = 1'b0;
        tick();
        chk("mc_starve_kept", 32'(starve_count), 32'd0);

        // Spurious ack in IDLE, then zero-wait ack
        force_ack = 1'b1;
        tick();
        chk("sp_valids", {30'd0, if_valid, d_valid}, 32'd0);
        chk("sp_state", 32'(fsm_state), 32'd0);
        tick();
        chk("sp_valids2", {30'd0, if_valid, d_valid}, 32'd0);
        mem_wait = 4'd0;
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        force_ack = 1'b0;
        #1;
        chk("zw_mem_req", 32'(mem_req), 32'd1);
        chk("zw_if_valid_low", 32'(if_valid), 32'd0);
        tick();
        chk("zw_if_valid", 32'(if_valid), 32'd1);
        chk("zw_if_rdata", if_rdata, 32'h0050_0093);
        if_req = 1'b0;
        tick();
        chk("zw_if_valid_off", 32'(if_valid), 32'd0);

        // Reset during BUSY_D with a 5-wait-state memory
        mem_wait = 4'd5;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'hCAFE_F00D;
        tick();
        chk("ra_mem_req", 32'(mem_req), 32'd1);
        chk("ra_mem_we", 32'(mem_we), 32'd1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("ra_mem_req_drop", 32'(mem_req), 32'd0);
        chk("ra_mem_we_drop", 32'(mem_we), 32'd0);
        chk("ra_mem_wdata_drop", mem_wdata, 32'h0);
        chk("ra_d_rdata_rst", d_rdata, 32'h0);
        chk("ra_d_valid", 32'(d_valid), 32'd0);
        tick();
        chk("ra_d_valid2", 32'(d_valid), 32'd0);
        chk("ra_stallM", 32'(stallM), 32'd1);
        tick();
        rst_n = 1'b1;
        mem_wait = 4'd1;
        #1;
        chk("ra_idle", 32'(fsm_state), 32'd0);
        tick();
        chk("ra2_mem_req", 32'(mem_req), 32'd1);
        chk("ra2_mem_addr", mem_addr, 32'h44);
        tick();
        chk("ra2_d_valid_low", 32'(d_valid), 32'd0);
        tick();
        chk("ra2_d_valid", 32'(d_valid), 32'd1);
        chk("ra2_d_rdata_store", d_rdata, 32'h0);
        chk("ra2_stallM", 32'(stallM), 32'd0);
        d_we = 1'b0;
        tick();
        mem_wait = 4'd0;
        tick();
        tick();
        chk("ra3_d_valid", 32'(d_valid), 32'd1);
        chk("ra3_d_rdata", d_rdata, 32'hCAFE_F00D);
        d_req = 1'b0;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
